// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced over one shared 4-bit ripple-carry slice.
// One nibble per clock, LSB first; valid/ready on both request and result.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic            c0;
    logic            carry_reg;
    logic            last;

    assign in_ready = (state == IDLE) && !rst;
    assign last     = (idx == IW'(NIB - 1));

    // Slice inputs are only live while stepping; otherwise held at zero.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx*4 +: 4];
            add_b   = b_reg[idx*4 +: 4];
            add_cin = (idx == '0) ? c0 : carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        c0    <= sub | cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*4 +: 4] <= add_s;
                    carry_reg       <= add_cout;
                    if (last) begin
                        idx       <= '0;
                        cout      <= add_cout;
                        // Overflow: like-signed operands, result sign differs.
                        ovf       <= (a_reg[MSB] == b_reg[MSB]) &&
                                     (add_s[3] != a_reg[MSB]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed and random operations
// against an arithmetic reference, with a behavioural 4-bit slice.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External ripple-carry slice: purely combinational.
    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Reference: {ovf, cout, sum} from plain arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c,
                                          input logic s);
        logic [16:0] r;
        logic [15:0] sm;
        logic        co;
        logic        ov;
        if (s) begin
            sm = x - y;
            co = (x >= y);
            ov = (x[15] != y[15]) && (sm[15] != x[15]);
        end else begin
            r  = 17'(x) + 17'(y) + 17'(c);
            sm = r[15:0];
            co = r[16];
            ov = (x[15] == y[15]) && (sm[15] != x[15]);
        end
        return {ov, co, sm};
    endfunction

    // Drive one request, then wait for the result; no checking here.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic is,
                         output int lat, output logic [3:0] cins);
        int w;
        lat  = -1;
        cins = 4'h0;
        w    = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) return;
        a        = ia;
        b        = ib;
        cin      = ic;
        sub      = is;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        for (int k = 0; k < 30; k++) begin
            if (out_valid) begin
                lat = k;
                return;
            end
            if (k < 4) cins[k] = add_cin;
            @(posedge clk); #1;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_result got=%h/%b/%b exp=0000/0/0",
                     sum, cout, ovf);
        end
        checks++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL rst_slice got=%h/%h/%b exp=0/0/0",
                     add_a, add_b, add_cin);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        int         lat;
        logic [3:0] cins;
        issue(16'h0005, 16'h0003, 1'b0, 1'b0, lat, cins);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=4", lat);
        end
        checks++;
        if (sum !== 16'h0008 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got=%h/%b/%b exp=0008/0/0",
                     sum, cout, ovf);
        end
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_handoff got rdy=%b vld=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_carry_chain();
        int         lat;
        logic [3:0] cins;
        issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, lat, cins);
        checks++;
        if (cins !== 4'b1110) begin
            errors++;
            $display("FAIL carry_cin_seq got=%b exp=1110", cins);
        end
        checks++;
        if (sum !== 16'h1000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_0fff got=%h/%b exp=1000/0", sum, cout);
        end
        handoff();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, cins);
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_ffff got=%h/%b/%b exp=0000/1/0",
                     sum, cout, ovf);
        end
        handoff();
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, lat, cins);
        checks++;
        if (sum !== 16'h0001 || cins !== 4'b0001) begin
            errors++;
            $display("FAIL carry_cin_only got=%h cins=%b exp=0001/0001",
                     sum, cins);
        end
        handoff();
    endtask

    task automatic test_overflow();
        logic [15:0] ta[5] = '{16'h7FFF, 16'h0005, 16'h8000,
                               16'h1234, 16'h8000};
        logic [15:0] tb[5] = '{16'h0001, 16'h0007, 16'h0001,
                               16'h1234, 16'h8000};
        logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [17:0] exp;
        int          lat;
        logic [3:0]  cins;
        for (int i = 0; i < 5; i++) begin
            exp = model(ta[i], tb[i], 1'b0, ts[i]);
            issue(ta[i], tb[i], 1'b0, ts[i], lat, cins);
            checks++;
            if ({ovf, cout, sum} !== exp || lat != 4) begin
                errors++;
                $display("FAIL ovf_case%0d got=%b/%b/%h exp=%b/%b/%h",
                         i, ovf, cout, sum, exp[17], exp[16], exp[15:0]);
            end
            handoff();
        end
    endtask

    task automatic test_stall();
        int          lat;
        logic [3:0]  cins;
        logic [15:0] s0;
        logic [17:0] exp;
        exp = model(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        issue(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, lat, cins);
        checks++;
        if ({ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL stall_result got=%b/%b/%h exp=%b/%b/%h",
                     ovf, cout, sum, exp[17], exp[16], exp[15:0]);
        end
        s0       = sum;
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || sum !== s0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got vld=%b sum=%h rdy=%b exp 1/%h/0",
                         k, out_valid, sum, in_ready, s0);
            end
        end
        in_valid = 1'b0;
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got rdy=%b vld=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        int         lat;
        logic [3:0] cins;
        logic       seen;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 16'h0) begin
            errors++;
            $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h exp 0/0/0000",
                     in_ready, out_valid, sum);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_ready got=%b exp=1", in_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrun_no_valid got out_valid=1 exp=0");
        end
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, lat, cins);
        checks++;
        if (sum !== 16'h2345 || lat != 4) begin
            errors++;
            $display("FAIL midrun_next got=%h lat=%0d exp=2345 lat=4",
                     sum, lat);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        logic [17:0] q[$];
        logic [17:0] exp;
        logic        acc;
        int          cyc;
        int          sent;
        int          got;
        int          last_rise;
        cyc       = 0;
        sent      = 0;
        got       = 0;
        last_rise = -1;
        out_ready = 1'b1;
        a         = 16'($urandom);
        b         = 16'($urandom);
        cin       = 1'($urandom);
        sub       = 1'($urandom);
        in_valid  = 1'b1;
        while (got < 200 && cyc < 2000) begin
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
                if (sent < 200) begin
                    a   = 16'($urandom);
                    b   = 16'($urandom);
                    cin = 1'($urandom);
                    sub = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : 18'h0;
                checks++;
                if ({ovf, cout, sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result%0d got=%b/%b/%h exp=%b/%b/%h",
                             got, ovf, cout, sum, exp[17], exp[16],
                             exp[15:0]);
                end
                if (last_rise >= 0) begin
                    checks++;
                    if (cyc - last_rise != 6) begin
                        errors++;
                        $display("FAIL b2b_period%0d got=%0d exp=6",
                                 got, cyc - last_rise);
                    end
                end
                last_rise = cyc;
                got++;
            end
        end
        checks++;
        if (got != 200) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=200", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        cin       = 1'b0;
        sub       = 1'b0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_overflow();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
